// File: rtl/serial_tx.sv
// serial_tx -- parallel-in, serial-out transmitter.
//
// A W-bit word is accepted on a valid/ready handshake. It is then shifted out
// on sdo_o with a generated bit clock sclk_o and a frame strobe fs_o. A
// receiver samples sdo_o on each sclk_o rising edge while fs_o is high.
//
// Parameters
//   W    word width in bits (>= 2)
//   DIV  clk_i cycles per sclk_o half-period (>= 1)
//   GAP  idle sclk_o periods between frames (>= 0)
//
// Ports
//   clk_i    system clock, rising edge
//   rst_n_i  asynchronous active-low reset
//   din_i    word to transmit, sampled on acceptance only
//   dir_i    bit order, sampled with din_i: 1 = LSB first, 0 = MSB first
//   valid_i  din_i/dir_i valid
//   ready_o  block can accept a word
//   sclk_o   bit clock
//   sdo_o    serial data, stable across each sclk_o high phase
//   fs_o     high while a word is being shifted
//   busy_o   high whenever the FSM is not idle
//   done_o   one-cycle pulse at the end of each word
//
// Optional feature: defining SERIAL_TX_BUF_EN adds a one-word holding register.
// A word accepted during a frame then starts as soon as that frame's gap ends,
// or seamlessly on the last falling edge when GAP = 0.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for a word; outputs quiet
// ST_SHIFT | frame in progress; fs_o high, sclk_o toggling
// ST_GAP   | inter-frame gap of GAP*2*DIV cycles; outputs quiet

module serial_tx #(
    parameter int W   = 8,
    parameter int DIV = 4,
    parameter int GAP = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] din_i,
    input  logic         dir_i,
    input  logic         valid_i,
    output logic         ready_o,
    output logic         sclk_o,
    output logic         sdo_o,
    output logic         fs_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int GAP_CYC = GAP * 2 * DIV;
    localparam int DCW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BCW     = $clog2(W);
    localparam int GCW     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(W - 1);
    localparam logic [GCW-1:0] GAP_LAST = (GAP_CYC > 0) ? GCW'(GAP_CYC - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e         state_q;
    logic [DCW-1:0] div_cnt_q;
    logic [BCW-1:0] bit_cnt_q;
    logic [GCW-1:0] gap_cnt_q;
    logic [W-1:0]   sr_q;
    logic           sclk_q;
    logic           sdo_q;
    logic           fs_q;
    logic           done_q;

    logic           accept;
    logic           frame_end;
    logic           load_now;
    logic [W-1:0]   word_d;

    // The shift register always shifts MSB-first, so an LSB-first word is
    // bit-reversed once when it is loaded.
    function automatic logic [W-1:0] to_msb_first(input logic [W-1:0] d,
                                                  input logic       lsb_first);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[i] = lsb_first ? d[W-1-i] : d[i];
        end
        return r;
    endfunction

    assign accept    = valid_i && ready_o;
    // Falling sclk edge that ends the last bit of the word.
    assign frame_end = (state_q == ST_SHIFT) && (div_cnt_q == DIV_LAST) &&
                       sclk_q && (bit_cnt_q == BIT_LAST);

`ifdef SERIAL_TX_BUF_EN
    logic [W-1:0] hold_q;
    logic         full_q;
    logic         load_point;

    assign ready_o    = !full_q;
    // Points where a queued (or freshly presented) word can start a frame
    // without an idle cycle in between.
    assign load_point = (frame_end && (GAP == 0)) ||
                        ((state_q == ST_GAP) && (gap_cnt_q == '0));
    assign word_d     = full_q ? hold_q : to_msb_first(din_i, dir_i);
    assign load_now   = ((state_q == ST_IDLE) && accept) ||
                        (load_point && (full_q || valid_i));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else if (accept && !load_now) begin
            hold_q <= to_msb_first(din_i, dir_i);
            full_q <= 1'b1;
        end else if (load_now && full_q) begin
            full_q <= 1'b0;
        end
    end
`else
    assign ready_o  = (state_q == ST_IDLE);
    assign word_d   = to_msb_first(din_i, dir_i);
    assign load_now = (state_q == ST_IDLE) && accept;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            sr_q      <= '0;
            sclk_q    <= 1'b0;
            sdo_q     <= 1'b0;
            fs_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_SHIFT: begin
                    if (div_cnt_q != DIV_LAST) begin
                        div_cnt_q <= div_cnt_q + DCW'(1);
                    end else begin
                        div_cnt_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else if (!frame_end) begin
                            sclk_q    <= 1'b0;
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                            sr_q      <= {sr_q[W-2:0], 1'b0};
                            sdo_q     <= sr_q[W-2];
                        end else begin
                            sclk_q    <= 1'b0;
                            sdo_q     <= 1'b0;
                            fs_q      <= 1'b0;
                            done_q    <= 1'b1;
                            bit_cnt_q <= '0;
                            if (GAP == 0) begin
                                state_q <= ST_IDLE;
                            end else begin
                                state_q   <= ST_GAP;
                                gap_cnt_q <= GAP_LAST;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GCW'(1);
                    end
                end
                default: begin
                end
            endcase

            // A load overrides whatever the current state decided, which lets
            // a new frame begin on the same edge that ends the previous one.
            if (load_now) begin
                state_q   <= ST_SHIFT;
                sr_q      <= word_d;
                sdo_q     <= word_d[W-1];
                fs_q      <= 1'b1;
                sclk_q    <= 1'b0;
                div_cnt_q <= '0;
                bit_cnt_q <= '0;
            end
        end
    end

    assign sclk_o = sclk_q;
    assign sdo_o  = sdo_q;
    assign fs_o   = fs_q;
    assign done_o = done_q;
    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_tx.sv
// Testbench for serial_tx. Three instances:
//   dut_a: W=8, DIV=2, GAP=1
//   dut_b: W=2, DIV=1, GAP=0
//   dut_c: W=8, DIV=2, GAP=0
// Every cycle of a frame is compared against a reference waveform computed
// arithmetically from the cycle index.

module tb_serial_tx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] din_a, din_c;
    logic [1:0] din_b;
    logic       dir_a, dir_b, dir_c;
    logic       valid_a, valid_b, valid_c;
    logic       ready_a, sclk_a, sdo_a, fs_a, busy_a, done_a;
    logic       ready_b, sclk_b, sdo_b, fs_b, busy_b, done_b;
    logic       ready_c, sclk_c, sdo_c, fs_c, busy_c, done_c;
    logic [5:0] obs_a, obs_b, obs_c;

    serial_tx #(.W(8), .DIV(2), .GAP(1)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .din_i(din_a), .dir_i(dir_a),
        .valid_i(valid_a), .ready_o(ready_a), .sclk_o(sclk_a), .sdo_o(sdo_a),
        .fs_o(fs_a), .busy_o(busy_a), .done_o(done_a));

    serial_tx #(.W(2), .DIV(1), .GAP(0)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .din_i(din_b), .dir_i(dir_b),
        .valid_i(valid_b), .ready_o(ready_b), .sclk_o(sclk_b), .sdo_o(sdo_b),
        .fs_o(fs_b), .busy_o(busy_b), .done_o(done_b));

    serial_tx #(.W(8), .DIV(2), .GAP(0)) dut_c (
        .clk_i(clk), .rst_n_i(rst_n), .din_i(din_c), .dir_i(dir_c),
        .valid_i(valid_c), .ready_o(ready_c), .sclk_o(sclk_c), .sdo_o(sdo_c),
        .fs_o(fs_c), .busy_o(busy_c), .done_o(done_c));

    // Observation vector: {ready, busy, fs, sclk, sdo, done}
    assign obs_a = {ready_a, busy_a, fs_a, sclk_a, sdo_a, done_a};
    assign obs_b = {ready_b, busy_b, fs_b, sclk_b, sdo_b, done_b};
    assign obs_c = {ready_c, busy_c, fs_c, sclk_c, sdo_c, done_c};

    localparam logic [5:0] IDLE_VEC = 6'b100000;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int p_w(input int id);
        return (id == 1) ? 2 : 8;
    endfunction
    function automatic int p_div(input int id);
        return (id == 1) ? 1 : 2;
    endfunction
    function automatic int p_gap(input int id);
        return (id == 0) ? 1 : 0;
    endfunction

    function automatic logic [5:0] obs(input int id);
        case (id)
            0:       return obs_a;
            1:       return obs_b;
            default: return obs_c;
        endcase
    endfunction

    task automatic set_in(input int id, input logic [7:0] w, input logic d, input logic v);
        case (id)
            0:       begin din_a = w;      dir_a = d; valid_a = v; end
            1:       begin din_b = w[1:0]; dir_b = d; valid_b = v; end
            default: begin din_c = w;      dir_c = d; valid_c = v; end
        endcase
    endtask

    // idx-th bit on the wire for word w of width wd sent in order d.
    function automatic logic bit_of(input logic [7:0] w, input logic d, input int idx, input int wd);
        int pos;
        pos = d ? idx : (wd - 1 - idx);
        return ((w >> pos) & 8'd1) != 8'd0;
    endfunction

    // Expected observation vector k cycles after the accepting edge.
    function automatic logic [5:0] model(input int id, input logic [7:0] w, input logic d, input int k);
        int   dv, tot, gapc;
        logic fs, sclk, sdo, done, busy, ready;
        dv   = p_div(id);
        tot  = p_w(id) * 2 * dv;
        gapc = p_gap(id) * 2 * dv;
        fs   = (k <= tot);
        sclk = fs && ((((k - 1) / dv) % 2) == 1);
        sdo  = fs && bit_of(w, d, (k - 1) / (2 * dv), p_w(id));
        done = (k == tot + 1);
        busy = (k <= tot + gapc);
`ifdef SERIAL_TX_BUF_EN
        ready = 1'b1;
`else
        ready = !busy;
`endif
        return {ready, busy, fs, sclk, sdo, done};
    endfunction

    task automatic idle(input int id, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            check_eq($sformatf("idle_%0d", id), 32'(obs(id)), 32'(IDLE_VEC));
        end
    endtask

    task automatic wait_ready(input int id);
        logic [5:0] v;
        int n;
        n = 0;
        v = obs(id);
        while (!v[5] && n < 100) begin
            @(negedge clk);
            n++;
            v = obs(id);
        end
        check_eq($sformatf("accept_wait_%0d", id), 32'(v[5]), 32'd1);
    endtask

    // Send one word and compare every cycle until the block is idle again.
    // abort_k > 0 asserts reset asynchronously during cycle abort_k.
    // hold_next presents 8'h3C with VALID held from cycle 5 on.
    task automatic run_frame(input int id, input logic [7:0] w, input logic d,
                             input int abort_k, input bit hold_next);
        int         wd, tot, last, nrx, nfs, ndone;
        logic [5:0] v, e;
        logic       prev_sclk;
        logic [7:0] rx, erx;
        wd   = p_w(id);
        tot  = wd * 2 * p_div(id);
        last = tot + p_gap(id) * 2 * p_div(id) + 1;
        set_in(id, w, d, 1'b1);
        wait_ready(id);
        @(posedge clk);
        #1;
        set_in(id, 8'($urandom), 1'($urandom), 1'b0);
        prev_sclk = 1'b0;
        nrx = 0; nfs = 0; ndone = 0; rx = '0;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            v = obs(id);
            e = model(id, w, d, k);
            check_eq($sformatf("cyc_%0d_w%0h_k%0d", id, w, k), 32'(v), 32'(e));
            if (v[3] && v[2] && !prev_sclk) begin
                rx = {rx[6:0], v[1]};
                nrx++;
            end
            prev_sclk = v[2];
            nfs   += int'(v[3]);
            ndone += int'(v[0]);
            if (hold_next && k == 5) set_in(id, 8'h3C, 1'b0, 1'b1);
            if (k == abort_k) begin
                #1 rst_n = 1'b0;
                #1;
                check_eq("rst_async", 32'(obs(id)), 32'(IDLE_VEC));
                return;
            end
        end
        erx = '0;
        for (int i = 0; i < wd; i++) erx = {erx[6:0], bit_of(w, d, i, wd)};
        check_eq($sformatf("rx_word_%0d", id), 32'(rx), 32'(erx));
        check_eq($sformatf("rx_bits_%0d", id), nrx, wd);
        check_eq($sformatf("fs_len_%0d", id), nfs, tot);
        check_eq($sformatf("done_cnt_%0d", id), ndone, 1);
    endtask

`ifdef SERIAL_TX_BUF_EN
    // Two words back-to-back into dut_c (GAP=0): one continuous 64-cycle frame.
    task automatic buf_pair();
        logic [15:0] stream, rx;
        logic [5:0]  v, e;
        logic        prev_sclk, fs_e;
        int          nrx, nfs, ndone;
        stream = 16'hF00F;
        set_in(2, 8'hF0, 1'b0, 1'b1);
        wait_ready(2);
        @(posedge clk);
        #1;
        set_in(2, 8'h0F, 1'b0, 1'b1);
        prev_sclk = 1'b0;
        nrx = 0; nfs = 0; ndone = 0; rx = '0;
        for (int k = 1; k <= 66; k++) begin
            @(negedge clk);
            if (k == 2) set_in(2, 8'h00, 1'b0, 1'b0);
            v = obs(2);
            fs_e = (k <= 64);
            e[5] = !(k >= 2 && k <= 32);
            e[4] = (k <= 64);
            e[3] = fs_e;
            e[2] = fs_e && ((((k - 1) / 2) % 2) == 1);
            e[1] = fs_e && stream[15 - ((k - 1) / 4)];
            e[0] = (k == 33) || (k == 65);
            check_eq($sformatf("buf_k%0d", k), 32'(v), 32'(e));
            if (v[3] && v[2] && !prev_sclk) begin
                rx = {rx[14:0], v[1]};
                nrx++;
            end
            prev_sclk = v[2];
            nfs   += int'(v[3]);
            ndone += int'(v[0]);
        end
        check_eq("buf_rx_word", 32'(rx), 32'(stream));
        check_eq("buf_rx_bits", nrx, 16);
        check_eq("buf_fs_len", nfs, 64);
        check_eq("buf_done_cnt", ndone, 2);
    endtask
`endif

    initial begin
        int id;
        rst_n = 1'b0;
        set_in(0, 8'h00, 1'b0, 1'b0);
        set_in(1, 8'h00, 1'b0, 1'b0);
        set_in(2, 8'h00, 1'b0, 1'b0);
        #12;
        check_eq("reset_a", 32'(obs_a), 32'(IDLE_VEC));
        check_eq("reset_b", 32'(obs_b), 32'(IDLE_VEC));
        check_eq("reset_c", 32'(obs_c), 32'(IDLE_VEC));
        @(negedge clk);
        rst_n = 1'b1;
        idle(0, 2);

        run_frame(0, 8'hA5, 1'b0, 0, 1'b0);
        idle(0, 1);
        run_frame(0, 8'h01, 1'b1, 0, 1'b0);
`ifndef SERIAL_TX_BUF_EN
        run_frame(0, 8'h55, 1'b0, 0, 1'b1);
        run_frame(0, 8'h3C, 1'b0, 0, 1'b0);
`endif

        // Reset in the middle of bit 3, then a clean word.
        run_frame(0, 8'hA5, 1'b0, 14, 1'b0);
        @(negedge clk);
        check_eq("rst_hold_a", 32'(obs_a), 32'(IDLE_VEC));
        check_eq("rst_hold_b", 32'(obs_b), 32'(IDLE_VEC));
        check_eq("rst_hold_c", 32'(obs_c), 32'(IDLE_VEC));
        rst_n = 1'b1;
        idle(0, 3);
        run_frame(0, 8'h81, 1'b0, 0, 1'b0);

        run_frame(1, 8'h02, 1'b0, 0, 1'b0);
        idle(1, 1);
        run_frame(1, 8'h01, 1'b1, 0, 1'b0);

        run_frame(2, 8'hC3, 1'b1, 0, 1'b0);
`ifdef SERIAL_TX_BUF_EN
        buf_pair();
`endif

        for (int i = 0; i < 15; i++) begin
            id = int'($urandom_range(0, 2));
            idle(id, int'($urandom_range(0, 3)));
            run_frame(id, 8'($urandom), 1'($urandom), 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parallel-in, serial-out transmitter. Accepts a W-bit word over a valid/ready handshake and shifts it out on SDO, with a generated bit clock SCLK and frame strobe FS.
- It is the transmit end of the codebase's serial links. It feeds any serial-in shift receiver that samples SDO on the SCLK rising edge while FS is high.

Parameters:
- W, 8, word width in bits; W >= 2.
- DIV, 4, CLK cycles per SCLK half-period; DIV >= 1.
- GAP, 1, idle SCLK periods (each 2*DIV CLK cycles) between frames; GAP >= 0.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- DIN  in  W  word to transmit; sampled on acceptance only.
- DIR  in  1  bit order, sampled with DIN: 1 = LSB first, 0 = MSB first.
- VALID  in  1  DIN/DIR valid.
- READY  out  1  block can accept a word.
- SCLK  out  1  bit clock; receiver samples SDO on its rising edge.
- SDO  out  1  serial data.
- FS  out  1  high while a word is being shifted.
- BUSY  out  1  high whenever state is not IDLE.
- DONE  out  1  one-cycle pulse at the end of each word.

Behaviour:
- Reset (RST_N=0, asynchronous): SCLK=0, SDO=0, FS=0, BUSY=0, DONE=0, READY=1, state IDLE. Counters and the shift register clear. A partial word is discarded and no DONE is issued.
- Acceptance: on a CLK rising edge with VALID&&READY. DIN and DIR are latched into the shift register. DIN need not be held afterwards.
- States:
  - IDLE: READY=1. On acceptance, go to SHIFT.
  - SHIFT: FS=1, BUSY=1. Bit counter runs 0..W-1; divider counter runs 0..DIV-1.
  - GAP: FS=0, SDO=0, BUSY=1 for GAP*2*DIV cycles, then go to IDLE. With GAP=0, go straight from SHIFT to IDLE.
- Timing:
  - Cycle after acceptance: FS=1, SCLK=0, SDO = first bit (DIN[W-1] if DIR=0, DIN[0] if DIR=1).
  - After DIV cycles SCLK goes 1. After another DIV cycles SCLK goes 0 and SDO advances to the next bit on that same edge.
  - SDO is stable for the whole SCLK-high phase. Each bit lasts exactly 2*DIV cycles; FS stays high for exactly W*2*DIV cycles.
- End of word: on the falling SCLK edge of bit W-1, FS, SCLK and SDO go 0 and DONE=1 for one cycle. The next state is GAP (or IDLE).
- Without buffer, READY=0 in SHIFT and GAP. VALID is ignored while READY=0; there is no error and no loss of the pending request.
- Counter widths use $clog2 of their range. No wrap-around occurs beyond the terminal counts.
- Minimum accept-to-accept interval (no buffer): 1 + W*2*DIV + GAP*2*DIV cycles.

Optional Feature:
- Macro SERIAL_TX_BUF_EN.
- Defined:
  - Adds a one-word holding register (data plus DIR) with a full flag. READY = !full in every state.
  - Acceptance in IDLE with the holder empty goes directly to the shift register, with the same latency as without the buffer.
  - Acceptance during SHIFT/GAP fills the holder. When the current frame's GAP ends, the holder loads into the shift register and SHIFT starts on that cycle.
  - With GAP=0, loading occurs on the last falling edge. FS then stays 1 continuously, SDO shows the new word's first bit on that edge, and DONE still pulses.
  - Reset clears the holder.
- Not defined: no holding register; READY = (state==IDLE).

Test Plan:
- Reset check: assert RST_N=0 mid-frame (during bit 3) -> all outputs immediately at reset values, no DONE. A following word 8'h81 with DIR=0 transmits correctly.
- W=8, DIV=2, GAP=1, DIN=8'hA5, DIR=0 -> SDO at SCLK rises = 1,0,1,0,0,1,0,1. FS high 32 cycles. One DONE pulse. READY returns 4 cycles after DONE.
- DIN=8'h01, DIR=1 -> bits 1,0,0,0,0,0,0,0. SDO is stable across every SCLK-high phase.
- VALID held with 8'h3C while busy (no buffer) -> READY=0 through SHIFT/GAP. 8'h3C accepted on the first cycle READY=1 and sent intact.
- DIV=1, W=2, GAP=0, DIN=2'b10, DIR=0 -> SCLK toggles every cycle, FS high 4 cycles, DONE on cycle 5 after accept, READY=1 the same cycle.
- SERIAL_TX_BUF_EN, W=8, DIV=2, GAP=0, words 8'hF0 then 8'h0F accepted back-to-back -> FS continuous 64 cycles, 16 SCLK rises carrying F0 then 0F, two DONE pulses 32 cycles apart.
